// File: rtl/qc_readout_pkg.sv
// Shared types and widths for the qubit readout path.
`timescale 1ns/1ps
package qc_readout_pkg;

    localparam int MAX_SITES = 128;
    localparam int SITE_ID_W = 7;
    localparam int COUNT_W   = 8;

    typedef logic [MAX_SITES-1:0] site_bitmap_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } agg_state_e;

endpackage

// File: rtl/atom_state_aggregator.sv
// Collects per-site Rydberg/ground decisions into a frame bitmap and hands
// the closed frame to the consumer over a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; last frame's results remain readable
// COLLECT | accepting samples; timer runs every cycle
// DONE    | frame closed (all sites or timeout); o_frame_valid held
`timescale 1ns/1ps
module atom_state_aggregator
    import qc_readout_pkg::*;
#(
    parameter int NUM_SITES      = 100,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic                 i_decision,
    input  logic [SITE_ID_W-1:0] i_base_id,
    input  logic                 i_frame_ready,
    output logic                 o_frame_valid,
    output logic [MAX_SITES-1:0] o_bitmap,
    output logic [MAX_SITES-1:0] o_recv_mask,
    output logic [COUNT_W-1:0]   o_rcv_count,
    output logic [COUNT_W-1:0]   o_ryd_count,
    output logic                 o_timeout,
    output logic                 o_dup_err,
    output logic                 o_id_err,
    output logic                 o_busy
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] NUM_SITES_C = COUNT_W'(NUM_SITES);

    agg_state_e          state_q, state_d;
    site_bitmap_t        bitmap_q, bitmap_d;
    site_bitmap_t        mask_q, mask_d;
    logic [COUNT_W-1:0]  rcv_q, rcv_d;
    logic [COUNT_W-1:0]  ryd_q, ryd_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                timeout_q, timeout_d;
    logic                dup_q, dup_d;
    logic                id_err_q, id_err_d;
    logic                complete;

    // Next-state and frame-content update; every field defaults to hold.
    always_comb begin
        state_d   = state_q;
        bitmap_d  = bitmap_q;
        mask_d    = mask_q;
        rcv_d     = rcv_q;
        ryd_d     = ryd_q;
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
        dup_d     = dup_q;
        id_err_d  = id_err_q;
        complete  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A sample coincident with i_start belongs to no frame.
                if (i_start) begin
                    bitmap_d  = '0;
                    mask_d    = '0;
                    rcv_d     = '0;
                    ryd_d     = '0;
                    tmr_d     = '0;
                    timeout_d = 1'b0;
                    dup_d     = 1'b0;
                    id_err_d  = 1'b0;
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                tmr_d = tmr_q + 1'b1;
                if (i_valid) begin
                    if ({1'b0, i_base_id} >= NUM_SITES_C) begin
                        id_err_d = 1'b1;
                    end else if (mask_q[i_base_id]) begin
                        dup_d = 1'b1;
                    end else begin
                        mask_d[i_base_id]   = 1'b1;
                        bitmap_d[i_base_id] = i_decision;
                        rcv_d               = rcv_q + 1'b1;
                        ryd_d               = ryd_q + COUNT_W'(i_decision);
                        complete            = (rcv_q + 1'b1 == NUM_SITES_C);
                    end
                end
                // Completion outranks timeout when both land on one edge.
                if (complete) begin
                    state_d = DONE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (i_frame_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and frame registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            bitmap_q  <= '0;
            mask_q    <= '0;
            rcv_q     <= '0;
            ryd_q     <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
            dup_q     <= 1'b0;
            id_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitmap_q  <= bitmap_d;
            mask_q    <= mask_d;
            rcv_q     <= rcv_d;
            ryd_q     <= ryd_d;
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
            dup_q     <= dup_d;
            id_err_q  <= id_err_d;
        end
    end

    assign o_frame_valid = (state_q == DONE);
    assign o_busy        = (state_q != IDLE);
    assign o_bitmap      = bitmap_q;
    assign o_recv_mask   = mask_q;
    assign o_rcv_count   = rcv_q;
    assign o_ryd_count   = ryd_q;
    assign o_timeout     = timeout_q;
    assign o_dup_err     = dup_q;
    assign o_id_err      = id_err_q;

endmodule

// File: tb/tb_atom_state_aggregator.sv
// Directed bench for atom_state_aggregator: a default-size instance and a
// short-timeout instance share the stimulus; each test resets both.
`timescale 1ns/1ps
module tb_atom_state_aggregator;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic         dec = 1'b0;
    logic [6:0]   id = '0;
    logic         ready = 1'b0;

    logic         a_fv, a_to, a_dup, a_ide, a_busy;
    logic [127:0] a_bm, a_mask;
    logic [7:0]   a_rcv, a_ryd;
    logic         b_fv, b_to, b_dup, b_ide, b_busy;
    logic [127:0] b_bm, b_mask;
    logic [7:0]   b_rcv, b_ryd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    atom_state_aggregator #(.NUM_SITES(100), .TIMEOUT_CYCLES(4096)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
        .i_decision(dec), .i_base_id(id), .i_frame_ready(ready),
        .o_frame_valid(a_fv), .o_bitmap(a_bm), .o_recv_mask(a_mask),
        .o_rcv_count(a_rcv), .o_ryd_count(a_ryd), .o_timeout(a_to),
        .o_dup_err(a_dup), .o_id_err(a_ide), .o_busy(a_busy)
    );

    atom_state_aggregator #(.NUM_SITES(100), .TIMEOUT_CYCLES(64)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
        .i_decision(dec), .i_base_id(id), .i_frame_ready(ready),
        .o_frame_valid(b_fv), .o_bitmap(b_bm), .o_recv_mask(b_mask),
        .o_rcv_count(b_rcv), .o_ryd_count(b_ryd), .o_timeout(b_to),
        .o_dup_err(b_dup), .o_id_err(b_ide), .o_busy(b_busy)
    );

    typedef struct {
        logic       v;
        logic       d;
        logic [6:0] id;
        logic [7:0] rcv;
        logic [7:0] ryd;
        logic       dup;
        logic       ide;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sid, input logic sdec);
        valid = 1'b1;
        id    = 7'(sid);
        dec   = sdec;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0; valid = 1'b0; dec = 1'b0; id = '0; ready = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " fv"},   a_fv,   0);
        chk({tag, " bm"},   a_bm,   0);
        chk({tag, " mask"}, a_mask, 0);
        chk({tag, " rcv"},  a_rcv,  0);
        chk({tag, " ryd"},  a_ryd,  0);
        chk({tag, " to"},   a_to,   0);
        chk({tag, " dup"},  a_dup,  0);
        chk({tag, " ide"},  a_ide,  0);
        chk({tag, " busy"}, a_busy, 0);
    endtask

    initial begin
        logic [127:0] exp_bm;
        logic [127:0] full_mask;

        vecs[0] = '{v:1'b1, d:1'b1, id:7'd5,   rcv:8'd1, ryd:8'd1, dup:1'b0, ide:1'b0};
        vecs[1] = '{v:1'b1, d:1'b0, id:7'd5,   rcv:8'd1, ryd:8'd1, dup:1'b1, ide:1'b0};
        vecs[2] = '{v:1'b1, d:1'b1, id:7'd120, rcv:8'd1, ryd:8'd1, dup:1'b1, ide:1'b1};
        vecs[3] = '{v:1'b0, d:1'b1, id:7'd7,   rcv:8'd1, ryd:8'd1, dup:1'b1, ide:1'b1};
        vecs[4] = '{v:1'b1, d:1'b0, id:7'd7,   rcv:8'd2, ryd:8'd1, dup:1'b1, ide:1'b1};
        vecs[5] = '{v:1'b1, d:1'b1, id:7'd99,  rcv:8'd3, ryd:8'd2, dup:1'b1, ide:1'b1};
        vecs[6] = '{v:1'b1, d:1'b1, id:7'd100, rcv:8'd3, ryd:8'd2, dup:1'b1, ide:1'b1};
        vecs[7] = '{v:1'b1, d:1'b1, id:7'd0,   rcv:8'd4, ryd:8'd3, dup:1'b1, ide:1'b1};

        exp_bm = '0;
        full_mask = '0;
        for (int i = 0; i < 100; i++) begin
            exp_bm[i]    = (i % 3 == 0);
            full_mask[i] = 1'b1;
        end

        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Full frame, decision = (ID%3==0)
        do_start();
        chk("t1 busy", a_busy, 1);
        for (int i = 0; i < 100; i++) begin
            if (i == 99) chk("t1 fv before last", a_fv, 0);
            send(i, (i % 3 == 0));
        end
        chk("t1 fv", a_fv, 1);
        chk("t1 rcv", a_rcv, 100);
        chk("t1 ryd", a_ryd, 34);
        chk("t1 bm", a_bm, exp_bm);
        chk("t1 mask", a_mask, full_mask);
        chk("t1 to", a_to, 0);
        for (int c = 0; c < 5; c++) begin
            valid = 1'b1; id = 7'd50; dec = 1'b0;
            tick();
            chk("t1 hold fv", a_fv, 1);
            chk("t1 hold rcv", a_rcv, 100);
            chk("t1 hold ryd", a_ryd, 34);
            chk("t1 hold bm", a_bm, exp_bm);
            chk("t1 hold dup", a_dup, 0);
        end
        valid = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("t1 busy after accept", a_busy, 0);
        chk("t1 fv after accept", a_fv, 0);
        chk("t1 rcv retained", a_rcv, 100);

        // Timeout on the 64-cycle instance with only IDs 0..9
        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) send(i, 1'b1);
        for (int c = 10; c < 63; c++) tick();
        chk("t2 fv before expiry", b_fv, 0);
        tick();
        chk("t2 fv", b_fv, 1);
        chk("t2 to", b_to, 1);
        chk("t2 rcv", b_rcv, 10);
        chk("t2 mask", b_mask, 128'h3FF);
        chk("t2 ryd", b_ryd, 10);

        // Duplicate and out-of-range IDs
        do_reset();
        do_start();
        for (int k = 0; k < 8; k++) begin
            valid = vecs[k].v; dec = vecs[k].d; id = vecs[k].id;
            tick();
            chk($sformatf("t3 v%0d rcv", k), a_rcv, vecs[k].rcv);
            chk($sformatf("t3 v%0d ryd", k), a_ryd, vecs[k].ryd);
            chk($sformatf("t3 v%0d dup", k), a_dup, vecs[k].dup);
            chk($sformatf("t3 v%0d ide", k), a_ide, vecs[k].ide);
        end
        valid = 1'b0;
        chk("t3 bm", a_bm, (128'd1 << 5) | (128'd1 << 99) | 128'd1);
        chk("t3 mask", a_mask, (128'd1 << 5) | (128'd1 << 7) | (128'd1 << 99) | 128'd1);

        // Samples in IDLE and with i_start; i_start inside COLLECT
        do_reset();
        for (int c = 0; c < 3; c++) send(c + 1, 1'b1);
        chk("t4 idle rcv", a_rcv, 0);
        chk("t4 idle busy", a_busy, 0);
        start = 1'b1; valid = 1'b1; id = 7'd3; dec = 1'b1;
        tick();
        start = 1'b0; valid = 1'b0;
        chk("t4 start rcv", a_rcv, 0);
        chk("t4 start mask", a_mask, 0);
        chk("t4 start busy", a_busy, 1);
        send(1, 1'b1);
        chk("t4 rcv1", a_rcv, 1);
        do_start();
        chk("t4 restart no clear", a_rcv, 1);
        start = 1'b1;
        send(2, 1'b0);
        start = 1'b0;
        chk("t4 restart+sample rcv", a_rcv, 2);
        chk("t4 restart+sample mask", a_mask, 128'h6);

        // Last missing ID lands in the timeout-expiry cycle
        do_reset();
        do_start();
        for (int i = 0; i < 99; i++) send(i, 1'b0);
        for (int c = 99; c < 4095; c++) tick();
        chk("t5 fv before", a_fv, 0);
        send(99, 1'b1);
        chk("t5 fv", a_fv, 1);
        chk("t5 rcv", a_rcv, 100);
        chk("t5 ryd", a_ryd, 1);
        chk("t5 to", a_to, 0);

        // Asynchronous reset mid-COLLECT, then a clean frame
        do_reset();
        do_start();
        send(10, 1'b1);
        send(11, 1'b1);
        send(120, 1'b0);
        chk("t6 pre rcv", a_rcv, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t6 async");
        #4 rst_n = 1'b1;
        tick();
        do_start();
        send(4, 1'b1);
        chk("t6 clean rcv", a_rcv, 1);
        chk("t6 clean ryd", a_ryd, 1);
        chk("t6 clean mask", a_mask, 128'h10);
        chk("t6 clean ide", a_ide, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
